// File: rtl/result_drain_pkg.sv
// Shared widths, FSM encodings and lane-index helper for result_drain.
// Optional RESULT_DRAIN_REVERSE_EN selects reverse lane emission order.
package result_drain_pkg;

   localparam int ADDRESSSIZE    = 10;
   localparam int PARTIAL_SUM_BW = 20;
   localparam int MATRIX_SIZE    = 8;
   localparam int CNT_W          = ADDRESSSIZE + 1;
   localparam int LANE_W         = $clog2(MATRIX_SIZE);
   localparam int WORD_W         = PARTIAL_SUM_BW * MATRIX_SIZE;

   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDRESSSIZE;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_SEND = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;

   // Buffer slice emitted for a given emission-order lane
   function automatic logic [LANE_W-1:0] lane_slice_idx(
      input logic [LANE_W-1:0] lane,
      input logic              rev
   );
      return rev ? (LANE_W'(MATRIX_SIZE - 1) - lane) : lane;
   endfunction

endpackage

// File: rtl/result_lane_serializer.sv
// Word buffer and lane serializer with valid/ready output handshake.
// RESULT_DRAIN_REVERSE_EN emits the top slice first.
module result_lane_serializer
   import result_drain_pkg::*;
(
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             i_load,
   input  logic [WORD_W-1:0]                i_word,
   input  logic                             i_last_word,
   input  logic                             i_ready,
   output logic                             o_valid,
   output logic signed [PARTIAL_SUM_BW-1:0] o_data,
   output logic [LANE_W-1:0]                o_lane,
   output logic                             o_last,
   output logic                             o_word_consumed
);

`ifdef RESULT_DRAIN_REVERSE_EN
   localparam logic REV = 1'b1;
`else
   localparam logic REV = 1'b0;
`endif

   logic [WORD_W-1:0]         r_buf;
   logic [LANE_W-1:0]         r_lane;
   logic                      r_valid;
   logic [PARTIAL_SUM_BW-1:0] w_lanes [MATRIX_SIZE];
   logic                      w_hs;
   logic                      w_end;

   always_comb begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
         w_lanes[i] = r_buf[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
      end
   end

   assign w_hs  = r_valid & i_ready;
   assign w_end = (r_lane == LANE_W'(MATRIX_SIZE - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_buf   <= '0;
         r_lane  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_buf   <= i_word;
         r_lane  <= '0;
         r_valid <= 1'b1;
      end else if (w_hs) begin
         if (w_end) r_valid <= 1'b0;
         else       r_lane  <= r_lane + 1'b1;
      end
   end

   assign o_valid         = r_valid;
   assign o_data          = w_lanes[lane_slice_idx(r_lane, REV)];
   assign o_lane          = r_lane;
   assign o_last          = r_valid & w_end & i_last_word;
   assign o_word_consumed = w_hs & w_end;

endmodule

// File: rtl/result_drain.sv
// Drains result words from the results SRAM as signed lane beats.
// Optional RESULT_DRAIN_REVERSE_EN reverses lane order (serializer).
module result_drain
   import result_drain_pkg::*;
(
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             start,
   input  logic [ADDRESSSIZE-1:0]           base_addr,
   input  logic [CNT_W-1:0]                 num_words,
   output logic                             busy,
   output logic                             done,
   output logic                             sram_rd_en,
   output logic [ADDRESSSIZE-1:0]           sram_rd_addr,
   input  logic [WORD_W-1:0]                sram_rd_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [PARTIAL_SUM_BW-1:0] out_data,
   output logic [LANE_W-1:0]                out_lane,
   output logic                             out_last
);

   logic [2:0]             r_state;
   logic [ADDRESSSIZE-1:0] r_addr;
   logic [CNT_W-1:0]       r_left;
   logic [CNT_W-1:0]       w_num;
   logic                   w_last_word;
   logic                   w_consumed;

   assign w_num       = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
   assign w_last_word = (r_left == CNT_W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_left  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     r_state <= ST_FIN;
                  end else begin
                     r_addr  <= base_addr;
                     r_left  <= w_num;
                     r_state <= ST_RD;
                  end
               end
            end
            ST_RD:   r_state <= ST_CAP;
            ST_CAP:  r_state <= ST_SEND;
            ST_SEND: begin
               if (w_consumed) begin
                  if (w_last_word) begin
                     r_state <= ST_FIN;
                  end else begin
                     // address wraps modulo 2^ADDRESSSIZE
                     r_addr  <= r_addr + 1'b1;
                     r_left  <= r_left - 1'b1;
                     r_state <= ST_RD;
                  end
               end
            end
            ST_FIN:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (r_state == ST_RD) | (r_state == ST_CAP)
                       | (r_state == ST_SEND);
   assign done         = (r_state == ST_FIN);
   assign sram_rd_en   = (r_state == ST_RD);
   assign sram_rd_addr = r_addr;

   result_lane_serializer u_ser (
      .clk             (clk),
      .rstn            (rstn),
      .i_load          (r_state == ST_CAP),
      .i_word          (sram_rd_data),
      .i_last_word     (w_last_word),
      .i_ready         (out_ready),
      .o_valid         (out_valid),
      .o_data          (out_data),
      .o_lane          (out_lane),
      .o_last          (out_last),
      .o_word_consumed (w_consumed)
   );

endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain with a 1-cycle SRAM model.
`timescale 1ns/1ps
module tb_result_drain;
   import result_drain_pkg::*;

`ifdef RESULT_DRAIN_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   logic                             clk = 1'b0;
   logic                             rstn = 1'b0;
   logic                             start = 1'b0;
   logic [ADDRESSSIZE-1:0]           base_addr = '0;
   logic [CNT_W-1:0]                 num_words = '0;
   logic                             busy;
   logic                             done;
   logic                             sram_rd_en;
   logic [ADDRESSSIZE-1:0]           sram_rd_addr;
   logic [WORD_W-1:0]                sram_rd_data = '0;
   logic                             out_valid;
   logic                             out_ready = 1'b0;
   logic signed [PARTIAL_SUM_BW-1:0] out_data;
   logic [LANE_W-1:0]                out_lane;
   logic                             out_last;

   result_drain dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .base_addr    (base_addr),
      .num_words    (num_words),
      .busy         (busy),
      .done         (done),
      .sram_rd_en   (sram_rd_en),
      .sram_rd_addr (sram_rd_addr),
      .sram_rd_data (sram_rd_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_lane     (out_lane),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   logic [WORD_W-1:0] mem [0:(1<<ADDRESSSIZE)-1];
   always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag,
                  $signed(got), $signed(exp));
      end
   endtask

   // hand-chosen lane contents per address
   function automatic int lv(input int a, input int l);
      if (a == 7)               return l + 1;
      else if (a == 4 || a == 5) return -(100 * a + l);
      else                      return a * 10 + l;
   endfunction

   function automatic logic [WORD_W-1:0] mkword(input int a);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int l = 0; l < MATRIX_SIZE; l++)
         w[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(lv(a, l));
      return w;
   endfunction

   int exp_d[$];
   int exp_l[$];
   bit exp_last[$];
   int hs_cyc[$];
   int rd_addr_q[$];
   int cyc = 0;
   int rd_cnt, valid_cnt, done_cnt, busy_cnt;
   int first_rd, first_val, done_cyc, last_hs, t0;
   int rdy_mode, rcnt;
   bit mon_on = 1'b0;
   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (mon_on) begin
      if (busy) busy_cnt++;
      if (sram_rd_en) begin
         rd_cnt++;
         rd_addr_q.push_back(int'(sram_rd_addr));
         if (first_rd < 0) first_rd = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_at_done", busy, 0);
      end
      if (out_valid) begin
         valid_cnt++;
         if (first_val < 0) first_val = cyc;
         check("rd_in_send", sram_rd_en, 0);
         if (exp_d.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            check("data", out_data, exp_d[0]);
            check("lane", out_lane, exp_l[0]);
            check("last", out_last, exp_last[0]);
            if (out_ready) begin
               void'(exp_d.pop_front());
               void'(exp_l.pop_front());
               void'(exp_last.pop_front());
               hs_cyc.push_back(cyc);
               last_hs = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
         out_ready = pat[rcnt % 4];
         rcnt++;
      end
   endtask

   task automatic clear(input int mode);
      exp_d.delete(); exp_l.delete(); exp_last.delete();
      hs_cyc.delete(); rd_addr_q.delete();
      rd_cnt = 0; valid_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_rd = -1; first_val = -1; done_cyc = -1; last_hs = -1;
      rdy_mode = mode; rcnt = 0;
      out_ready = (mode != 2);
   endtask

   task automatic push_word(input int a, input bit last);
      for (int l = 0; l < MATRIX_SIZE; l++) begin
         exp_d.push_back(lv(a, REV ? MATRIX_SIZE - 1 - l : l));
         exp_l.push_back(l);
         exp_last.push_back(last && l == MATRIX_SIZE - 1);
      end
   endtask

   task automatic do_start(input int b, input int n);
      base_addr = ADDRESSSIZE'(b);
      num_words = CNT_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input int lim);
      int k;
      k = 0;
      while (done_cnt == 0 && k < lim) begin
         tick();
         k++;
      end
      check("timeout", done_cnt > 0, 1);
      repeat (3) tick();
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rd_en"}, sram_rd_en, 0);
      check({tag, "_addr"}, sram_rd_addr, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_lane"}, out_lane, 0);
      check({tag, "_last"}, out_last, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      foreach (mem[a]) mem[a] = '0;
      foreach (mem[a]) if (a < 8 || a == 1023) mem[a] = mkword(a);
      clear(0);
      repeat (2) tick();
      check_reset_outs("rst");
      rstn = 1'b1;
      mon_on = 1'b1;
      tick();

      // basic drain, latency, bubble and done timing
      clear(0);
      push_word(0, 0);
      push_word(1, 1);
      do_start(0, 2);
      wait_done(100);
      check("basic_left", exp_d.size(), 0);
      check("basic_rd_cnt", rd_cnt, 2);
      check("basic_rd_a0", rd_addr_q[0], 0);
      check("basic_rd_a1", rd_addr_q[1], 1);
      check("basic_rd_lat", first_rd - t0 + 1, 1);
      check("basic_val_lat", first_val - t0 + 1, 3);
      check("basic_gap", hs_cyc[8] - hs_cyc[7], 3);
      check("basic_done_lat", done_cyc - last_hs, 1);
      check("basic_done_cnt", done_cnt, 1);
      check("basic_valid_cnt", valid_cnt, 16);

      // backpressure 1,0,0,1 with an ignored start mid-drain
      clear(1);
      push_word(4, 0);
      push_word(5, 1);
      do_start(4, 2);
      repeat (4) tick();
      base_addr = '0;
      num_words = CNT_W'(5);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(300);
      check("bp_left", exp_d.size(), 0);
      check("bp_rd_cnt", rd_cnt, 2);
      check("bp_rd_a0", rd_addr_q[0], 4);
      check("bp_rd_a1", rd_addr_q[1], 5);
      check("bp_done_cnt", done_cnt, 1);
      check("bp_idle", busy, 0);

      // zero-length start
      clear(0);
      do_start(3, 0);
      repeat (4) tick();
      check("zero_done_cnt", done_cnt, 1);
      check("zero_done_lat", done_cyc - t0 + 1, 1);
      check("zero_rd_cnt", rd_cnt, 0);
      check("zero_valid_cnt", valid_cnt, 0);
      check("zero_busy_cnt", busy_cnt, 0);

      // address wrap 1023 -> 0
      clear(0);
      push_word(1023, 0);
      push_word(0, 1);
      do_start(1023, 2);
      wait_done(100);
      check("wrap_left", exp_d.size(), 0);
      check("wrap_rd_cnt", rd_cnt, 2);
      check("wrap_rd_a0", rd_addr_q[0], 1023);
      check("wrap_rd_a1", rd_addr_q[1], 0);

      // asynchronous reset while stalled in SEND
      clear(2);
      push_word(1, 0);
      do_start(1, 2);
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      check("mid_reach_send", out_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outs("mid");
      repeat (3) tick();
      check("mid_no_done", done_cnt, 0);
      rstn = 1'b1;
      tick();
      clear(0);
      push_word(0, 1);
      do_start(0, 1);
      wait_done(100);
      check("post_left", exp_d.size(), 0);
      check("post_rd_cnt", rd_cnt, 1);
      check("post_done_cnt", done_cnt, 1);

      // lanes 1..8: natural or reversed emission order
      clear(0);
      push_word(7, 1);
      do_start(7, 1);
      wait_done(100);
      check("order_left", exp_d.size(), 0);
      check("order_done_cnt", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Reads back result words of PARTIAL_SUM_BW*MATRIX_SIZE bits from the results SRAM (1-cycle synchronous read port).
- Serializes each word into MATRIX_SIZE signed partial-sum lanes on a valid/ready output stream.
- Sits between the results SRAM read port and the host/next stage. It is the consumer side of the result write path filled by the vector multiplier.

Parameters:
- ADDRESSSIZE, 10, results SRAM address width
- PARTIAL_SUM_BW, 20, bits per lane (signed partial sum)
- MATRIX_SIZE, 8, lanes per SRAM word
- CNT_W, 11, width of the word-count input (ADDRESSSIZE+1)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  launch a drain; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first SRAM word address, latched on accepted start
- num_words  in  CNT_W  number of words to drain, latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after final handshake
- sram_rd_en  out  1  read strobe to results SRAM
- sram_rd_addr  out  ADDRESSSIZE  read address
- sram_rd_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  read data, valid the cycle after sram_rd_en
- out_valid  out  1  lane data valid
- out_ready  in  1  downstream accept
- out_data  out  PARTIAL_SUM_BW  current lane, signed
- out_lane  out  $clog2(MATRIX_SIZE)  current lane index
- out_last  out  1  high on the final lane of the final word

Behaviour:
- Reset: state IDLE. All outputs are 0, including busy, done, sram_rd_en, sram_rd_addr, out_valid, out_data, out_lane and out_last. Internal word buffer and counters are cleared.
- States: IDLE, RD, CAP, SEND, FIN.
- IDLE:
  - start=1 with num_words>0: latch base_addr/num_words and go to RD.
  - start=1 with num_words=0: go to FIN (done pulse, no reads, no output).
  - start is ignored in every other state.
- RD (1 cycle): sram_rd_en=1, sram_rd_addr=current address; go to CAP.
- CAP (1 cycle): capture sram_rd_data into the word buffer, set lane=0, go to SEND.
- SEND:
  - out_valid=1; out_data=buffer lane slice [lane*PSUM +: PSUM].
  - Lane 0 = bits [PSUM-1:0].
  - A handshake is out_valid & out_ready.
  - Without a handshake: out_data, out_lane and out_last stay stable.
  - Handshake on a lane below MATRIX_SIZE-1: lane+1.
  - Handshake on lane MATRIX_SIZE-1:
    - if words remain: address+1, words_left-1, go to RD.
    - else: go to FIN.
- FIN: done=1 for one cycle, busy=0 from this cycle, return to IDLE.
- Latency:
  - Accepted start at edge N gives sram_rd_en in cycle N+1 and first out_valid in cycle N+3.
  - Inter-word bubble is 2 cycles (RD+CAP). out_valid=0 during the bubble.
- Address wrap: address increments modulo 2^ADDRESSSIZE (1023 -> 0).
- out_last = (lane==MATRIX_SIZE-1) && (words_left==1) in SEND.
- out_ready held low indefinitely stalls in SEND with no SRAM reads issued.
- Reset mid-operation: immediate return to IDLE, no done pulse, partial word discarded.
- Max num_words = 2^ADDRESSSIZE. Larger values are clamped to 2^ADDRESSSIZE.

Optional Feature:
- Macro: RESULT_DRAIN_REVERSE_EN.
- Defined: lanes are emitted in reverse order. The first lane is the buffer slice MATRIX_SIZE-1 (top bits), the last is slice 0. out_lane still counts 0..MATRIX_SIZE-1 in emission order.
- Undefined: natural order, slice 0 first.

Decomposition:
- Package result_drain_pkg:
  - state enum (IDLE, RD, CAP, SEND, FIN)
  - LANE_W = $clog2(MATRIX_SIZE)
  - lane-slice helper function
- One sub-module, result_lane_serializer:
  - holds the word buffer, lane counter, out_valid/out_ready handshake and reverse-order option
  - asserts word_consumed on the final-lane handshake
- Top FSM: address/word counters and SRAM strobes.

Test Plan:
- Basic drain: preload addr 0..1 with lanes k*10+lane; start with base 0, num_words 2, out_ready=1 → 16 beats 0,1,..,7,10,..,17; out_last on beat 16; done pulse 1 cycle after; sram_rd_en exactly twice.
- Latency: start at edge 0 → sram_rd_en cycle 1 (addr 0), out_valid first in cycle 3; 2-cycle gap between lane 7 and the next word's lane 0.
- Backpressure: out_ready toggles 1,0,0,1 repeating → every lane delivered exactly once in order; out_data stable while valid&!ready; no SRAM read during stall.
- Zero/ignored starts: num_words=0 → done pulse cycle 1, no out_valid, no sram_rd_en; start pulsed while busy → ignored, count unchanged.
- Wrap and reset: base 1023, num_words 2 → reads addr 1023 then 0; assert rstn low mid-SEND → all outputs 0 asynchronously, no done; new start after release works.
- RESULT_DRAIN_REVERSE_EN defined: word with lanes 0..7 = 1..8 → out_data 8,7,..,1 with out_lane 0..7.
